// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t   : controller FSM states
//   ADDR_*    : next-PC source select encodings driven on AddrSel
//   LDCNT_W   : width of the load-use wait counter
package hazard_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_WAIT   = 3'd1,
        JUMP      = 3'd2,
        BR_EVAL   = 3'd3,
        BR_SQUASH = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_PC4 = 2'b00;
    localparam logic [1:0] ADDR_JMP = 2'b01;
    localparam logic [1:0] ADDR_BR  = 2'b10;
    localparam logic [1:0] ADDR_REG = 2'b11;

    localparam int unsigned LDCNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   Clk   : clock
//   Rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use and jr data hazards, sequences jump/branch squashing and
// drives the fetch-side enables and next-PC select (combinational, Mealy).
//   Clk, Rst                    : clock, synchronous active-high reset
//   Jump, Jr, Branch            : control-flow instruction in ID
//   BranchTaken                 : EX branch outcome, used in BR_EVAL
//   MemReadEX, PrevRt           : load in EX and its destination
//   MemStall                    : external memory freeze
//   CurrRs, CurrRt              : ID sources; UseShamt/UseImmed mask them
//   EX_/MEM_RegWrite, EX_/MEM_Rw: pending writebacks (jr operand check)
//   IF_write, PC_write, Bubble  : IF/ID enable, PC enable, ID/EX zeroing
//   AddrSel                     : next-PC source select
//   StallCount                  : saturating count of PC_write=0 cycles
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned R0_SAFE  = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Jump,
    input  logic              Jr,
    input  logic              Branch,
    input  logic              BranchTaken,
    input  logic              MemReadEX,
    input  logic              MemStall,
    input  logic [REG_AW-1:0] CurrRs,
    input  logic [REG_AW-1:0] CurrRt,
    input  logic [REG_AW-1:0] PrevRt,
    input  logic              UseShamt,
    input  logic              UseImmed,
    input  logic              EX_RegWrite,
    input  logic              MEM_RegWrite,
    input  logic [REG_AW-1:0] EX_Rw,
    input  logic [REG_AW-1:0] MEM_Rw,
    output logic              IF_write,
    output logic              PC_write,
    output logic              Bubble,
    output logic [1:0]        AddrSel,
    output logic [CNT_W-1:0]  StallCount
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LDCNT_W-1:0] r_ldcnt;
    logic [LDCNT_W-1:0] w_ldcnt_nxt;
    logic               w_prevrt_z;
    logic               w_currrs_z;
    logic               w_ld_haz;
    logic               w_jr_haz;

    // Register 0 is hardwired, so it can be excluded from hazard matching.
    assign w_prevrt_z = (R0_SAFE != 0) && (PrevRt == '0);
    assign w_currrs_z = (R0_SAFE != 0) && (CurrRs == '0);

    assign w_ld_haz = MemReadEX
                   && (((CurrRs == PrevRt) && !UseShamt) || ((CurrRt == PrevRt) && !UseImmed))
                   && !w_prevrt_z;

    // jr reads Rs in ID, so any in-flight write to Rs must land first.
    assign w_jr_haz = Jr
                   && ((EX_RegWrite && (EX_Rw == CurrRs)) || (MEM_RegWrite && (MEM_Rw == CurrRs)))
                   && !w_currrs_z;

    // State and load-wait counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_ldcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ldcnt <= w_ldcnt_nxt;
        end
    end

    // Next state and Mealy outputs; MemStall freezes everything first.
    always_comb begin
        IF_write    = 1'b1;
        PC_write    = 1'b1;
        Bubble      = 1'b0;
        AddrSel     = ADDR_PC4;
        w_state_nxt = r_state;
        w_ldcnt_nxt = r_ldcnt;

        if (MemStall) begin
            IF_write = 1'b0;
            PC_write = 1'b0;
        end else if (Rst) begin
            w_state_nxt = IDLE;
            w_ldcnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ld_haz || w_jr_haz) begin
                        IF_write = 1'b0;
                        PC_write = 1'b0;
                        Bubble   = 1'b1;
                        if (w_ld_haz && (LOAD_LAT > 1)) begin
                            w_state_nxt = LD_WAIT;
                            w_ldcnt_nxt = LDCNT_W'(LOAD_LAT - 1);
                        end
                    end else begin
                        if (Jr) begin
                            AddrSel = ADDR_REG;
                        end else if (Jump) begin
                            AddrSel = ADDR_JMP;
                        end
                        if (Branch) begin
                            w_state_nxt = BR_EVAL;
                        end else if (Jump) begin
                            w_state_nxt = JUMP;
                        end
                    end
                end
                LD_WAIT: begin
                    IF_write = 1'b0;
                    PC_write = 1'b0;
                    Bubble   = 1'b1;
                    if (r_ldcnt <= LDCNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_ldcnt_nxt = '0;
                    end else begin
                        w_ldcnt_nxt = r_ldcnt - LDCNT_W'(1);
                    end
                end
                JUMP: begin
                    Bubble      = 1'b1;
                    w_state_nxt = IDLE;
                end
                BR_EVAL: begin
                    if (BranchTaken) begin
                        Bubble      = 1'b1;
                        AddrSel     = ADDR_BR;
                        w_state_nxt = BR_SQUASH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                BR_SQUASH: begin
                    Bubble      = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_ldcnt_nxt = '0;
                end
            endcase
        end
    end

    // Counts every frozen-PC cycle, memory stalls included.
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (!PC_write),
        .count (StallCount)
    );

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core. It detects load-use and jump-register data hazards, sequences control-hazard squashing for jumps and branches, and drives the IF/ID write enables, PC write enable, ID/EX bubble and next-PC source select. Beyond single-cycle load stalls, it adds:
- configurable load-to-use latency;
- an external memory-stall freeze;
- register-0 hazard suppression;
- a JR register-target select;
- a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 5, register-specifier width
- LOAD_LAT, 1, load-use stall cycles (legal 1..7)
- R0_SAFE, 1, when 1, register 0 never creates a hazard
- CNT_W, 32, stall counter width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset: synchronous, active-high
- Jump  in  1  ID holds j/jal/jr
- Jr  in  1  ID holds jr (Jump also high)
- Branch  in  1  ID holds beq/bne
- BranchTaken  in  1  EX branch condition, valid in BR_EVAL
- MemReadEX  in  1  EX holds a load
- MemStall  in  1  external memory not ready
- CurrRs, CurrRt  in  REG_AW  ID source registers
- PrevRt  in  REG_AW  EX load destination
- UseShamt, UseImmed  in  1  ID ignores Rs / Rt
- EX_RegWrite, MEM_RegWrite  in  1  writeback pending in EX / MEM
- EX_Rw, MEM_Rw  in  REG_AW  destinations in EX / MEM
- IF_write  out  1  IF/ID register enable
- PC_write  out  1  PC enable
- Bubble  out  1  zero ID/EX control
- AddrSel  out  2  00 PC+4, 01 jump target, 10 branch target, 11 register (jr)
- StallCount  out  CNT_W  cycles with PC_write=0

## Operation
Hazard terms:
- z(r) = R0_SAFE && r==0.
- LdHaz = MemReadEX && ((CurrRs==PrevRt && !UseShamt) || (CurrRt==PrevRt && !UseImmed)) && !z(PrevRt).
- JrHaz = Jr && ((EX_RegWrite && EX_Rw==CurrRs) || (MEM_RegWrite && MEM_Rw==CurrRs)) && !z(CurrRs).

Priority: MemStall > Rst-forced defaults > state logic.
- MemStall=1: IF_write=0, PC_write=0, Bubble=0, AddrSel=00. State and load counter hold.
- "Stall" outputs: IF_write=0, PC_write=0, Bubble=1, AddrSel=00.
- "Pass" outputs: 1, 1, 0, 00.

States, encoded in the package:
- IDLE:
  - LdHaz|JrHaz: stall. Next state is LD_WAIT with ldcnt=LOAD_LAT-1 if LdHaz and LOAD_LAT>1, else IDLE.
  - Otherwise pass. AddrSel=11 if Jr, 01 if Jump, else 00.
  - Next state: BR_EVAL if Branch, else JUMP if Jump, else IDLE.
  - Branch outranks Jump.
- LD_WAIT: stall. ldcnt decrements; at ldcnt==1 next state is IDLE.
- JUMP: Bubble=1, IF_write=PC_write=1, AddrSel=00. Next state IDLE.
- BR_EVAL:
  - BranchTaken: Bubble=1, AddrSel=10, next BR_SQUASH.
  - Else: pass, next IDLE.
- BR_SQUASH: Bubble=1, AddrSel=00. Next state IDLE.

Hazard checks are evaluated only in IDLE. In a data-hazard cycle, Branch/Jump in ID do not advance the FSM; they are re-presented next cycle.

StallCount increments on every cycle where PC_write=0, including MemStall cycles. It saturates at all-ones.

## Timing
- Outputs are combinational (Mealy) from state and inputs, with zero-cycle latency. State, ldcnt and StallCount are registered.
- Reset values (Rst high at a rising edge): state IDLE, ldcnt 0, StallCount 0.
- While Rst=1: IF_write=1, PC_write=1, Bubble=0, AddrSel=00, regardless of state, unless MemStall=1.
- Reset asserted mid-LD_WAIT or mid-BR_EVAL aborts the sequence; no squash is issued.
- Load-use stall length: exactly LOAD_LAT cycles of PC_write=0, excluding any added MemStall cycles.
- Jump: one pass cycle with the target selected, then one bubble cycle.
- Branch: one evaluation cycle, plus one squash cycle if taken.
- MemStall during BR_EVAL delays the evaluation; BranchTaken is sampled on the first non-stalled cycle.

## Structure
- hazard_pkg holds:
  - the state enum (IDLE, LD_WAIT, JUMP, BR_EVAL, BR_SQUASH);
  - the AddrSel constants ADDR_PC4, ADDR_JMP, ADDR_BR, ADDR_REG.
- Sub-module sat_counter (parameter W; ports Clk, Rst, inc, count) implements StallCount.
- ldcnt width is 3 bits.

## Test plan
- LOAD_LAT=1: lw r5 in EX (MemReadEX=1, PrevRt=5), CurrRs=5 -> one cycle of PC_write=0, Bubble=1; StallCount=1.
- LOAD_LAT=3, same stimulus with MemReadEX dropping after the first cycle -> 3 consecutive stall cycles, then pass; StallCount=3.
- R0_SAFE=1, PrevRt=0, CurrRt=0, UseImmed=0 -> no stall. R0_SAFE=0 -> one stall.
- Jr with CurrRs=31, EX_RegWrite=1, EX_Rw=31 -> stall. Next cycle with no hazard: AddrSel=11, then a JUMP-state bubble.
- Branch then BranchTaken=1 -> BR_EVAL gives AddrSel=10, Bubble=1; BR_SQUASH gives Bubble=1. With BranchTaken=0 -> BR_EVAL passes, back to IDLE.
- MemStall=1 for 2 cycles during LD_WAIT -> outputs frozen, ldcnt held; total PC_write=0 cycles = LOAD_LAT+2. Rst mid-BR_EVAL -> IDLE next cycle, StallCount=0.
